// File: rtl/mul_pipe_arbiter_bf16_pkg.sv
// Shared types and helpers for the bf16 multiplier arbiter: bf16 constants,
// the response entry layout and the rotate-priority grant function.
package mul_arb_pkg;

  localparam int BF16_W = 16;
  localparam int MAX_ID_W = 4;

  localparam logic [BF16_W-1:0] BF16_ONE = 16'h3F80;
  localparam logic [BF16_W-1:0] BF16_TWO = 16'h4000;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [BF16_W-1:0]   z;
  } resp_entry_t;

  // First requester after ptr (wrapping modulo n) whose bit is set; ptr if none.
  function automatic logic [MAX_ID_W-1:0] next_rr(
    input logic [MAX_ID_W-1:0] ptr,
    input logic [15:0]         req,
    input int                  n
  );
    logic [MAX_ID_W-1:0] pick;
    logic                found;
    int                  idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k <= n) && !found && req[idx]) begin
        pick  = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_pipe_arbiter_bf16_if.sv
// Requester, multiplier and response signals of the bf16 multiplier arbiter.
// The slave view is the arbiter itself; master is the surrounding datapath.
interface mul_pipe_arbiter_bf16_if #(
  parameter int DW    = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);

  logic [N_REQ-1:0]      req_stb;
  logic [N_REQ*2*DW-1:0] req_data;
  logic [N_REQ-1:0]      req_ack;

  logic [2*DW-1:0]       mul_in;
  logic                  mul_stb;
  logic                  mul_ack;
  logic [DW-1:0]         mul_z;
  logic                  mul_z_stb;

  logic [DW-1:0]         resp_z;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_stb;
  logic                  resp_ack;

  logic                  busy;
  logic                  err_orphan;

  modport master (
    output req_stb, req_data, mul_ack, mul_z, mul_z_stb, resp_ack,
    input  req_ack, mul_in, mul_stb, resp_z, resp_id, resp_stb, busy, err_orphan
  );

  modport slave (
    input  req_stb, req_data, mul_ack, mul_z, mul_z_stb, resp_ack,
    output req_ack, mul_in, mul_stb, resp_z, resp_id, resp_stb, busy, err_orphan
  );

endinterface

// File: rtl/mul_pipe_arbiter_bf16_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with an occupancy count; a push
// while full is accepted only when a pop frees the head in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mul_pipe_arbiter_bf16.sv
// Round-robin front end sharing one bf16 multiplier between N_REQ requesters;
// a tag FIFO pairs in-order results with requester IDs, credit bounds buffering.
module mul_pipe_arbiter_bf16
  import mul_arb_pkg::*;
#(
  parameter int DW    = BF16_W,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  mul_pipe_arbiter_bf16_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    tag_head;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      tag_count;
  logic [CW-1:0]      out_count;
  logic [ID_W+DW-1:0] out_head;
  logic               credit_ok;
  logic               any_req;
  logic               issue;
  logic               tag_empty;
  logic               result_ok;
  logic               orphan;
  logic               resp_pop;
  logic               err_q;

  // Results still in the pipe already own an output slot, so count them too.
  assign credit_ok = ({1'b0, inflight} + {1'b0, out_count}) < (CW + 1)'(DEPTH);
  assign any_req   = |bus.req_stb;
  assign grant     = ID_W'(next_rr(MAX_ID_W'(rr_ptr), 16'(bus.req_stb), N_REQ));
  assign issue     = any_req && credit_ok && bus.mul_ack;

  assign bus.mul_stb = any_req && credit_ok;
  assign bus.mul_in  = bus.req_data[grant*2*DW +: 2*DW];

  always_comb begin
    bus.req_ack = '0;
    if (issue) bus.req_ack[grant] = 1'b1;
  end

  assign tag_empty = (tag_count == '0);
  assign result_ok = bus.mul_z_stb && !tag_empty;
  assign orphan    = bus.mul_z_stb && tag_empty;
  assign resp_pop  = bus.resp_stb && bus.resp_ack;

  sync_fifo_fwft #(
    .WIDTH (ID_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (grant),
    .pop   (result_ok),
    .dout  (tag_head),
    .count (tag_count)
  );

  sync_fifo_fwft #(
    .WIDTH (ID_W + DW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (result_ok),
    .din   ({tag_head, bus.mul_z}),
    .pop   (resp_pop),
    .dout  (out_head),
    .count (out_count)
  );

  assign bus.resp_stb   = (out_count != '0);
  assign bus.resp_id    = out_head[DW +: ID_W];
  assign bus.resp_z     = out_head[DW-1:0];
  assign bus.busy       = (inflight != '0) || bus.resp_stb;
  assign bus.err_orphan = err_q;

  // Issue and return in the same cycle cancel out; an orphan result touches no counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= ID_W'(N_REQ - 1);
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      if (issue) rr_ptr <= grant;
      if (issue && !result_ok)      inflight <= inflight + CW'(1);
      else if (!issue && result_ok) inflight <= inflight - CW'(1);
      if (orphan) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_pipe_arbiter_bf16.sv
// Self-checking bench for mul_pipe_arbiter_bf16: a 3-stage multiplier stand-in,
// a queue-level reference model, directed scenarios and a randomized run.
module tb_mul_pipe_arbiter_bf16;
  import mul_arb_pkg::*;

  localparam int DW    = 16;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_orphan = 1'b0;

  always #5 clk = ~clk;

  mul_pipe_arbiter_bf16_if #(.DW(DW), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  mul_pipe_arbiter_bf16 #(
    .DW    (DW),
    .N_REQ (N_REQ),
    .ID_W  (ID_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Truncating bf16 multiply for normal operands; zero exponent means zero.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          e;
    logic [15:0] p;
    logic [6:0]  m;
    s = a[15] ^ b[15];
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {s, 15'h0};
    p = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (p[15]) begin
      m = p[14:8];
      e = e + 1;
    end else begin
      m = p[13:7];
    end
    return {s, e[7:0], m};
  endfunction

  // Multiplier stand-in: fixed three-cycle latency, flushed by the shared reset.
  logic [2:0]    pipe_stb;
  logic [DW-1:0] pipe_z [3];

  always @(posedge clk) begin
    if (rst) pipe_stb <= '0;
    else     pipe_stb <= {pipe_stb[1:0], bus.mul_stb & bus.mul_ack};
    pipe_z[0] <= bf16_mul(bus.mul_in[2*DW-1:DW], bus.mul_in[DW-1:0]);
    pipe_z[1] <= pipe_z[0];
    pipe_z[2] <= pipe_z[1];
  end

  assign bus.mul_z     = pipe_z[2];
  assign bus.mul_z_stb = pipe_stb[2] | force_orphan;

  resp_entry_t          m_inflight [$];
  resp_entry_t          m_out [$];
  int                   m_rr;
  logic                 m_err;
  logic [N_REQ-1:0]     last_ack;
  logic [DW-1:0]        req_a [N_REQ];
  logic [DW-1:0]        req_b [N_REQ];
  int                   ack_log [$];
  logic [ID_W+DW-1:0]   pop_log [$];
  int                   obs_issues;
  int                   n_checks = 0;
  int                   n_fail = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*2*DW +: 2*DW] = {req_a[i], req_b[i]};
  endtask

  function automatic logic [15:0] rand_bf16();
    logic [15:0] v;
    v = {1'($urandom_range(1)), 8'($urandom_range(134, 120)), 7'($urandom_range(127))};
    if ($urandom_range(9) == 0) v = 16'h0000;
    return v;
  endfunction

  task automatic new_pair(input int i);
    req_a[i] = rand_bf16();
    req_b[i] = rand_bf16();
  endtask

  // Reference model: grant by rotating scan, results tracked as queues of {id, product}.
  task automatic model_step();
    int               g;
    int               idx;
    bit               credit;
    bit               exp_stb;
    logic [N_REQ-1:0] exp_ack;
    resp_entry_t      e;
    if (rst) begin
      m_inflight.delete();
      m_out.delete();
      m_rr     = N_REQ - 1;
      m_err    = 1'b0;
      last_ack = '0;
      return;
    end
    credit = (m_inflight.size() + m_out.size()) < DEPTH;
    g = -1;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (m_rr + k) % N_REQ;
      if (g < 0 && bus.req_stb[idx]) g = idx;
    end
    exp_stb = (g >= 0) && credit;
    exp_ack = (exp_stb && bus.mul_ack) ? (N_REQ'(1) << g) : '0;

    checkOutput("mul_stb", bus.mul_stb, exp_stb);
    checkOutput("req_ack", bus.req_ack, exp_ack);
    if (exp_stb) checkOutput("mul_in", bus.mul_in, {req_a[g], req_b[g]});
    checkOutput("resp_stb", bus.resp_stb, m_out.size() != 0);
    if (m_out.size() != 0) begin
      checkOutput("resp_z", bus.resp_z, m_out[0].z);
      checkOutput("resp_id", bus.resp_id, m_out[0].id);
    end
    checkOutput("busy", bus.busy, (m_inflight.size() != 0) || (m_out.size() != 0));
    checkOutput("err_orphan", bus.err_orphan, m_err);
    checkOutput("inflight", dut.inflight, m_inflight.size());
    checkOutput("tag_count", dut.tag_count, m_inflight.size());
    checkOutput("out_count", dut.out_count, m_out.size());

    if ((m_out.size() != 0) && bus.resp_ack) begin
      pop_log.push_back({bus.resp_id, bus.resp_z});
      void'(m_out.pop_front());
    end
    if (bus.mul_z_stb) begin
      if (m_inflight.size() != 0) m_out.push_back(m_inflight.pop_front());
      else m_err = 1'b1;
    end
    if (exp_ack != '0) begin
      e.id = MAX_ID_W'(g);
      e.z  = bf16_mul(req_a[g], req_b[g]);
      m_inflight.push_back(e);
      m_rr = g;
      ack_log.push_back(g);
    end
    if (bus.req_ack != '0) obs_issues++;
    last_ack = exp_ack;
  endtask

  task automatic tick();
    #4;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req_stb  = '0;
    bus.mul_ack  = 1'b1;
    bus.resp_ack = 1'b1;
  endtask

  // Requesters hold until acked, then either stream a new pair or drop.
  task automatic applyStimulus(input int p_req, input int p_mack, input int p_rack);
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_stb[i] && last_ack[i]) begin
        if ($urandom_range(99) < p_req) new_pair(i);
        else bus.req_stb[i] = 1'b0;
      end else if (!bus.req_stb[i] && ($urandom_range(99) < p_req)) begin
        new_pair(i);
        bus.req_stb[i] = 1'b1;
      end
    end
    bus.mul_ack  = ($urandom_range(99) < p_mack);
    bus.resp_ack = ($urandom_range(99) < p_rack);
    drive_data();
  endtask

  logic [DW-1:0] t1_a [4] = '{BF16_ONE, 16'h4040, 16'h3FC0, 16'h0000};
  logic [DW-1:0] t1_b [4] = '{BF16_TWO, BF16_TWO, 16'h3FC0, BF16_TWO};
  logic [DW-1:0] t1_z [4] = '{16'h4000, 16'h40C0, 16'h4010, 16'h0000};

  initial begin
    int              k;
    int              ack_cyc [$];
    logic [2*DW-1:0] held;

    for (int i = 0; i < N_REQ; i++) begin
      req_a[i] = '0;
      req_b[i] = '0;
    end
    bus.req_stb  = '0;
    bus.req_data = '0;
    bus.mul_ack  = 1'b0;
    bus.resp_ack = 1'b0;
    obs_issues   = 0;
    do_reset();
    do_reset();

    checkOutput("rst_mul_stb", bus.mul_stb, 1'b0);
    checkOutput("rst_req_ack", bus.req_ack, 4'b0000);
    checkOutput("rst_resp_stb", bus.resp_stb, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_rr_ptr", dut.rr_ptr, 2'd3);

    $display("[TB] scenario 1: single requester stream");
    ack_log.delete();
    pop_log.delete();
    bus.mul_ack  = 1'b1;
    bus.resp_ack = 1'b1;
    k = 0;
    req_a[0] = t1_a[0];
    req_b[0] = t1_b[0];
    bus.req_stb[0] = 1'b1;
    drive_data();
    for (int c = 0; c < 24 && (k < 4 || bus.busy); c++) begin
      tick();
      if (last_ack[0]) begin
        ack_cyc.push_back(c);
        k++;
        if (k < 4) begin
          req_a[0] = t1_a[k];
          req_b[0] = t1_b[k];
        end else begin
          bus.req_stb[0] = 1'b0;
        end
        drive_data();
      end
    end
    checkOutput("t1_acks", ack_cyc.size(), 4);
    if (ack_cyc.size() == 4) checkOutput("t1_ack_span", ack_cyc[3] - ack_cyc[0], 3);
    checkOutput("t1_pops", pop_log.size(), 4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++)
      checkOutput("t1_resp", pop_log[i], {2'b00, t1_z[i]});
    checkOutput("t1_busy_end", bus.busy, 1'b0);

    $display("[TB] scenario 2: all requesters from reset");
    idle_inputs();
    do_reset();
    for (int i = 0; i < N_REQ; i++) new_pair(i);
    bus.req_stb = '1;
    drive_data();
    ack_log.delete();
    for (int c = 0; c < 12; c++) begin
      tick();
      applyStimulus(100, 100, 100);
    end
    checkOutput("t2_issue_count", ack_log.size(), 12);
    for (int i = 0; i < 8 && i < ack_log.size(); i++)
      checkOutput("t2_grant_order", ack_log[i], i % N_REQ);
    bus.req_stb = '0;
    for (int c = 0; c < 10; c++) tick();

    $display("[TB] scenario 3: output backpressure");
    idle_inputs();
    bus.resp_ack = 1'b0;
    do_reset();
    new_pair(2);
    bus.req_stb[2] = 1'b1;
    drive_data();
    obs_issues = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (last_ack[2]) begin
        new_pair(2);
        drive_data();
      end
    end
    checkOutput("t3_issues", obs_issues, 8);
    checkOutput("t3_stalled", bus.mul_stb, 1'b0);
    checkOutput("t3_full", dut.out_count, DEPTH);
    bus.resp_ack = 1'b1;
    tick();
    bus.resp_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (last_ack[2]) begin
        new_pair(2);
        drive_data();
      end
    end
    checkOutput("t3_one_more", obs_issues, 9);
    checkOutput("t3_stalled_again", bus.mul_stb, 1'b0);
    checkOutput("t3_full_again", dut.out_count, DEPTH);
    bus.req_stb  = '0;
    bus.resp_ack = 1'b1;
    for (int c = 0; c < 12; c++) tick();

    $display("[TB] scenario 4: multiplier stall");
    idle_inputs();
    do_reset();
    bus.mul_ack = 1'b0;
    new_pair(1);
    bus.req_stb[1] = 1'b1;
    drive_data();
    held = {req_a[1], req_b[1]};
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("t4_no_ack", bus.req_ack, 4'b0000);
      checkOutput("t4_rr_hold", dut.rr_ptr, 2'd3);
      checkOutput("t4_data_held", bus.mul_in, held);
    end
    bus.mul_ack = 1'b1;
    #1;
    checkOutput("t4_resume", bus.req_ack, 4'b0010);
    tick();
    checkOutput("t4_rr_moved", dut.rr_ptr, 2'd1);
    bus.req_stb = '0;
    for (int c = 0; c < 8; c++) tick();

    $display("[TB] scenario 5: orphan result");
    idle_inputs();
    do_reset();
    force_orphan = 1'b1;
    tick();
    force_orphan = 1'b0;
    checkOutput("t5_err_set", bus.err_orphan, 1'b1);
    checkOutput("t5_no_resp", bus.resp_stb, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    checkOutput("t5_err_sticky", bus.err_orphan, 1'b1);
    checkOutput("t5_still_empty", bus.resp_stb, 1'b0);
    do_reset();
    checkOutput("t5_err_cleared", bus.err_orphan, 1'b0);

    $display("[TB] scenario 6: reset mid-operation");
    idle_inputs();
    bus.resp_ack = 1'b0;
    do_reset();
    new_pair(0);
    bus.req_stb[0] = 1'b1;
    drive_data();
    for (int c = 0; c < 5; c++) begin
      tick();
      if (last_ack[0]) begin
        new_pair(0);
        drive_data();
      end
    end
    checkOutput("t6_inflight", dut.inflight, 3);
    checkOutput("t6_out_count", dut.out_count, 2);
    bus.req_stb = 4'b1010;
    new_pair(1);
    new_pair(3);
    drive_data();
    do_reset();
    checkOutput("t6_resp_stb", bus.resp_stb, 1'b0);
    checkOutput("t6_busy", bus.busy, 1'b0);
    checkOutput("t6_mul_stb", bus.mul_stb, 1'b1);
    checkOutput("t6_first_grant", bus.req_ack, 4'b0010);
    bus.req_stb  = '0;
    bus.resp_ack = 1'b1;
    for (int c = 0; c < 10; c++) tick();

    $display("[TB] random phase");
    idle_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(60, 75, 60);
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 30; c++) tick();
    checkOutput("final_idle", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
